// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port round-robin arbiter in front of a single-port data RAM
//            with one-cycle read latency. Port 0 is the CPU data port, port 1
//            the debug/loader master, which may hold a bounded lock for bursts.
//            Byte addresses are converted to word indices, and read data is
//            routed back to the master that issued the read.
// Ports    : clk, rst (synchronous, active-high)
//            m0_* / m1_* : req, we, addr, wdata in; gnt, rvalid, rdata, err out
//            m1_lock     : port 1 asks to keep ownership on consecutive cycles
//            mem_*       : RAM we, addr (word index), wdata out; rdata in
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 10,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_we,
  output logic [IDX_W-1:0]  mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [7:0] c_max_lock = 8'(MAX_LOCK);

  // Arbitration state
  logic             r_last;      // port that won the most recent grant
  logic             r_m1_prev;   // port 1 was granted in the previous cycle
  logic [7:0]       r_lock_cnt;  // consecutive locked grants to port 1

  // Held RAM address/data so the bus does not toggle on idle cycles
  logic [IDX_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  // Return tag for the access granted in the previous cycle
  logic r_rd_valid;
  logic r_err_valid;
  logic r_tag_port;
  logic r_tag_mis;

  logic              w_lock;
  logic              w_g0;
  logic              w_g1;
  logic              w_gnt;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;
  logic              w_win_we;
  logic              w_aligned;

  // Upper address bits beyond the RAM depth are intentionally ignored.
  logic w_unused_addr;
  assign w_unused_addr = ^{m0_addr[ADDR_W-1:IDX_W+2], m1_addr[ADDR_W-1:IDX_W+2]};

  // Grant decision. The lock only applies to an ongoing port-1 run: port 1
  // must have been granted last cycle and still be asking to lock, and the
  // run must not yet have reached MAX_LOCK grants.
  always_comb begin
    w_g0   = 1'b0;
    w_g1   = 1'b0;
    w_lock = r_m1_prev && m1_req && m1_lock && (r_lock_cnt < c_max_lock);
    if (!rst) begin
      if (m0_req && m1_req) begin
        if (w_lock)      w_g1 = 1'b1;
        else if (r_last) w_g0 = 1'b1;
        else             w_g1 = 1'b1;
      end else begin
        w_g0 = m0_req;
        w_g1 = m1_req;
      end
    end
  end

  assign w_gnt       = w_g0 | w_g1;
  assign w_win_addr  = w_g1 ? m1_addr  : m0_addr;
  assign w_win_wdata = w_g1 ? m1_wdata : m0_wdata;
  assign w_win_we    = w_g1 ? m1_we    : m0_we;
  assign w_aligned   = (w_win_addr[1:0] == 2'b00);

  assign m0_gnt    = w_g0;
  assign m1_gnt    = w_g1;
  // Misaligned writes are granted but never reach the RAM.
  assign mem_we    = w_gnt && w_win_we && w_aligned;
  assign mem_addr  = w_gnt ? w_win_addr[IDX_W+1:2] : r_mem_addr;
  assign mem_wdata = w_gnt ? w_win_wdata           : r_mem_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last      <= 1'b1;
      r_m1_prev   <= 1'b0;
      r_lock_cnt  <= 8'd0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_valid  <= 1'b0;
      r_err_valid <= 1'b0;
      r_tag_port  <= 1'b0;
      r_tag_mis   <= 1'b0;
    end else begin
      r_m1_prev <= w_g1;
      if (w_gnt) begin
        r_last      <= w_g1;
        r_mem_addr  <= w_win_addr[IDX_W+1:2];
        r_mem_wdata <= w_win_wdata;
      end
      // Count locked port-1 grants; saturate so an idle port 0 lets the
      // burst continue indefinitely.
      if (w_g1 && m1_lock) begin
        if (r_lock_cnt != c_max_lock) r_lock_cnt <= r_lock_cnt + 8'd1;
      end else begin
        r_lock_cnt <= 8'd0;
      end
      r_rd_valid  <= w_gnt && !w_win_we;
      r_err_valid <= w_gnt && !w_aligned;
      r_tag_port  <= w_g1;
      r_tag_mis   <= !w_aligned;
    end
  end

  // Returned data is steered only to the tagged port; a misaligned read
  // returns zero instead of whatever the RAM happened to produce.
  assign m0_rvalid = r_rd_valid && !r_tag_port;
  assign m1_rvalid = r_rd_valid &&  r_tag_port;
  assign m0_err    = r_err_valid && !r_tag_port;
  assign m1_err    = r_err_valid &&  r_tag_port;
  assign m0_rdata  = (m0_rvalid && !r_tag_mis) ? mem_rdata : '0;
  assign m1_rdata  = (m1_rvalid && !r_tag_mis) ? mem_rdata : '0;

endmodule
`default_nettype wire
